// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the EX stage and the iterative mul/div sequencer.
interface muldiv_sequencer_if #(parameter int W = 32);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (output start, op, a, b,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add/subtract step per clock.
//  state | meaning
//  IDLE  | waiting for start, hi/lo hold the last result
//  RUN   | W magnitude iterations (shift-add or restoring shift-subtract)
//  FIX   | sign correction; corrected result loads hi/lo on the edge into DONE
//  DONE  | done/div_by_zero pulse, hi/lo valid
module muldiv_sequencer #(
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           busy_q, done_q, dbz_q;
  logic [W-1:0]   hi_q, lo_q;
  logic           is_div, neg_q, neg_r, b_zero;
  logic [W-1:0]   ma, mb, a_orig;
  logic [2*W-1:0] acc;

  logic           sa, sb;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     add_sum, shl_rem, sub_diff;
  logic [2*W-1:0] step_mul, step_div, acc_neg;
  logic [W-1:0]   q_fix, r_fix;

  always_comb begin
    sa    = bus.op[0] & bus.a[W-1];
    sb    = bus.op[0] & bus.b[W-1];
    a_mag = sa ? -bus.a : bus.a;
    b_mag = sb ? -bus.b : bus.b;

    // acc = {partial product, remaining multiplier bits}
    add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, ma} : '0);
    step_mul = {add_sum, acc[W-1:1]};

    // acc = {partial remainder, dividend bits / quotient bits}
    shl_rem  = {acc[2*W-1:W], acc[W-1]};
    sub_diff = shl_rem - {1'b0, mb};
    if (!sub_diff[W]) step_div = {sub_diff[W-1:0], acc[W-2:0], 1'b1};
    else              step_div = {shl_rem[W-1:0],  acc[W-2:0], 1'b0};

    acc_neg = -acc;
    q_fix   = neg_q ? -acc[W-1:0]   : acc[W-1:0];
    r_fix   = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      a_orig <= '0;
      acc    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            cnt    <= '0;
            busy_q <= 1'b1;
            is_div <= bus.op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (bus.b == '0);
            ma     <= a_mag;
            mb     <= b_mag;
            a_orig <= bus.a;
            acc    <= {{W{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          end
        end
        RUN: begin
          acc <= is_div ? step_div : step_mul;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          done_q <= 1'b1;
          if (is_div) begin
            // divide by zero still takes the full run, then reports the raw dividend
            if (b_zero) begin
              hi_q  <= a_orig;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end else begin
            {hi_q, lo_q} <= neg_q ? acc_neg : acc;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
